// File: rtl/tile_pixel_sel.sv
`default_nettype none
// ============================================================================
//  Module      : tile_pixel_sel
//  Description : Two-stage VGA pixel selector for a 4x4 tile board. Stage 0
//                locates the pixel on the board and looks up the tile code.
//                Stage 1 registers the tile-image address. Stage 2 registers
//                the colour taken from the decoded memory pixel bus.
//  Option      : `define TILE_SEL_SNAPSHOT_EN latches the board once per frame
//                (v_cnt==480, h_cnt==0) and uses that copy for tile lookup.
//                Without it, the live board input is used.
//  Revision    : 1.0  initial release
// ============================================================================
module tile_pixel_sel #(
  parameter int          BOARD_X0  = 120,
  parameter int          BOARD_Y0  = 40,
  parameter int          TILE_W    = 100,
  parameter logic [11:0] BG_COLOR  = 12'hBBA,
  parameter logic [11:0] ERR_COLOR = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        valid,
  input  logic [63:0] board,
  output logic [18:0] pixel_addr,
  input  logic [11:0] signal0,
  input  logic [11:0] signal1,
  input  logic [11:0] signal2,
  input  logic [11:0] signal3,
  input  logic [11:0] signal4,
  input  logic [11:0] signal5,
  input  logic [11:0] signal6,
  input  logic [11:0] signal7,
  input  logic [11:0] signal8,
  input  logic [11:0] signal9,
  input  logic [11:0] signal10,
  input  logic [11:0] signal11,
  output logic [11:0] rgb_out,
  output logic        rgb_valid
);

  // Board extents and tile boundaries, in 11 bits so X0 + 4*W never overflows.
  localparam logic [10:0] X_LO = 11'(BOARD_X0);
  localparam logic [10:0] X_HI = 11'(BOARD_X0 + 4 * TILE_W);
  localparam logic [10:0] Y_LO = 11'(BOARD_Y0);
  localparam logic [10:0] Y_HI = 11'(BOARD_Y0 + 4 * TILE_W);
  localparam logic [10:0] T1   = 11'(TILE_W);
  localparam logic [10:0] T2   = 11'(2 * TILE_W);
  localparam logic [10:0] T3   = 11'(3 * TILE_W);
  localparam logic [18:0] STRIDE = 19'(TILE_W);

  // --------------------------------------------------------------------------
  // Board source: per-frame snapshot or live input
  // --------------------------------------------------------------------------
  logic [63:0] board_sel;

`ifdef TILE_SEL_SNAPSHOT_EN
  logic [63:0] snap_q;
  logic [63:0] snap_d;

  // Capture the board at the start of vertical blanking so a frame never tears.
  always_comb begin
    snap_d = snap_q;
    if ((v_cnt == 10'd480) && (h_cnt == 10'd0)) begin
      snap_d = board;
    end
  end

  // Snapshot register, cleared to an all-empty board.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= 64'd0;
    end else begin
      snap_q <= snap_d;
    end
  end

  assign board_sel = snap_q;
`else
  assign board_sel = board;
`endif

  // --------------------------------------------------------------------------
  // Stage 0: board location, tile lookup and address computation
  // --------------------------------------------------------------------------
  logic [10:0] h_ext;
  logic [10:0] v_ext;
  logic [10:0] x_rel;
  logic [10:0] y_rel;
  logic [10:0] tx;
  logic [10:0] ty;
  logic [1:0]  col;
  logic [1:0]  row;
  logic        x_in;
  logic        y_in;
  logic [3:0]  tile_idx;

  logic [18:0] pixel_addr_d;
  logic [18:0] pixel_addr_q;
  logic [3:0]  code_s1_d;
  logic [3:0]  code_s1_q;
  logic        on_board_s1_d;
  logic        on_board_s1_q;
  logic        valid_s1_d;
  logic        valid_s1_q;

  assign h_ext = {1'b0, h_cnt};
  assign v_ext = {1'b0, v_cnt};

  // Locate the pixel by comparing against the tile boundaries (no divider);
  // the top comparison is >= so the last pixel stays in column/row 3.
  always_comb begin
    x_in  = (h_ext >= X_LO) && (h_ext < X_HI);
    y_in  = (v_ext >= Y_LO) && (v_ext < Y_HI);
    x_rel = h_ext - X_LO;
    y_rel = v_ext - Y_LO;

    if (x_rel >= T3) begin
      col = 2'd3;
      tx  = x_rel - T3;
    end else if (x_rel >= T2) begin
      col = 2'd2;
      tx  = x_rel - T2;
    end else if (x_rel >= T1) begin
      col = 2'd1;
      tx  = x_rel - T1;
    end else begin
      col = 2'd0;
      tx  = x_rel;
    end

    if (y_rel >= T3) begin
      row = 2'd3;
      ty  = y_rel - T3;
    end else if (y_rel >= T2) begin
      row = 2'd2;
      ty  = y_rel - T2;
    end else if (y_rel >= T1) begin
      row = 2'd1;
      ty  = y_rel - T1;
    end else begin
      row = 2'd0;
      ty  = y_rel;
    end

    tile_idx = {row, col};
  end

  // Next values for stage 1: address is forced to zero off the board.
  always_comb begin
    on_board_s1_d = valid && x_in && y_in;
    valid_s1_d    = valid;
    code_s1_d     = board_sel[{tile_idx, 2'b00} +: 4];
    pixel_addr_d  = 19'd0;
    if (on_board_s1_d) begin
      pixel_addr_d = (19'(ty) * STRIDE) + 19'(tx);
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: address edge
  // --------------------------------------------------------------------------
  // Register the memory address together with the tile code and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_addr_q  <= 19'd0;
      code_s1_q     <= 4'd0;
      on_board_s1_q <= 1'b0;
      valid_s1_q    <= 1'b0;
    end else begin
      pixel_addr_q  <= pixel_addr_d;
      code_s1_q     <= code_s1_d;
      on_board_s1_q <= on_board_s1_d;
      valid_s1_q    <= valid_s1_d;
    end
  end

  assign pixel_addr = pixel_addr_q;

  // --------------------------------------------------------------------------
  // Stage 2: memory-data edge
  // --------------------------------------------------------------------------
  logic [11:0] rgb_out_d;
  logic [11:0] rgb_out_q;
  logic        rgb_valid_d;
  logic        rgb_valid_q;

  // Pick the tile image matching the code; codes above 11 flag a bad board.
  always_comb begin
    rgb_valid_d = valid_s1_q;
    rgb_out_d   = BG_COLOR;
    if (on_board_s1_q) begin
      case (code_s1_q)
        4'd0:    rgb_out_d = signal0;
        4'd1:    rgb_out_d = signal1;
        4'd2:    rgb_out_d = signal2;
        4'd3:    rgb_out_d = signal3;
        4'd4:    rgb_out_d = signal4;
        4'd5:    rgb_out_d = signal5;
        4'd6:    rgb_out_d = signal6;
        4'd7:    rgb_out_d = signal7;
        4'd8:    rgb_out_d = signal8;
        4'd9:    rgb_out_d = signal9;
        4'd10:   rgb_out_d = signal10;
        4'd11:   rgb_out_d = signal11;
        default: rgb_out_d = ERR_COLOR;
      endcase
    end
  end

  // Output colour register, aligned with the memory pixel bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_out_q   <= 12'h000;
      rgb_valid_q <= 1'b0;
    end else begin
      rgb_out_q   <= rgb_out_d;
      rgb_valid_q <= rgb_valid_d;
    end
  end

  assign rgb_out   = rgb_out_q;
  assign rgb_valid = rgb_valid_q;

endmodule
`default_nettype wire

// File: doc/tile_pixel_sel.md
TILE_PIXEL_SEL -- requirements
Module: tile_pixel_sel

Interface
REQ-001 SHALL have parameter BOARD_X0, default 120: left edge of the 4x4 board, in pixels.
REQ-002 SHALL have parameter BOARD_Y0, default 40: top edge of the board, in lines.
REQ-003 SHALL have parameter TILE_W, default 100: tile width and height in pixels; also the stride of the tile images.
REQ-004 SHALL have parameters BG_COLOR, default 12'hBBA, and ERR_COLOR, default 12'hF0F: off-board colour and illegal-code colour.
REQ-005 SHALL have port clk, input, 1 bit: the single clock for all state.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have ports h_cnt and v_cnt, input, 10 bits each: VGA pixel and line counters.
REQ-008 SHALL have port valid, input, 1 bit: active-video qualifier for h_cnt and v_cnt.
REQ-009 SHALL have port board, input, 64 bits: tile k = row*4+col occupies bits [4k+3:4k]; code 0 is empty; codes 1..11 are 2..2048.
REQ-010 SHALL have port pixel_addr, output, 19 bits: address driven to the tile image memories.
REQ-011 SHALL have ports signal0..signal11, input, 12 bits each: decoded memory pixels, valid one clk after pixel_addr.
REQ-012 SHALL have port rgb_out, output, 12 bits: the selected pixel colour.
REQ-013 SHALL have port rgb_valid, output, 1 bit: rgb_out corresponds to an active pixel.

Function
REQ-014 SHALL treat a pixel as on-board when valid=1, BOARD_X0<=h_cnt<BOARD_X0+4*TILE_W and BOARD_Y0<=v_cnt<BOARD_Y0+4*TILE_W.
REQ-015 SHALL derive col, row and local tx, ty by comparing against tile boundaries, with no divider.
REQ-016 SHALL register pixel_addr = ty*TILE_W+tx (zero-extended to 19 bits) at edge 1 after sampling; off-board pixels SHALL give pixel_addr = 0.
REQ-017 SHALL carry tile code, on-board flag and valid through stage 1 (address edge) and stage 2 (memory-data edge).
REQ-018 SHALL register rgb_out at edge 2, aligned with signalN; total latency from h_cnt/v_cnt to rgb_out is 2 clk edges, and one pixel is accepted every cycle.
REQ-019 SHALL select rgb_out as follows: on-board with code c<=11 gives signal[c]; on-board with code 12..15 gives ERR_COLOR; off-board or valid=0 gives BG_COLOR.
REQ-020 SHALL set rgb_valid to the valid input delayed by 2 edges.
REQ-021 SHALL resolve col/row 3 at the last board pixel (x0+399, y0+399) with tx=ty=99, never wrapping to tile 0.

Reset
REQ-022 SHALL, while rst_n=0, force pixel_addr=0, rgb_out=12'h000, rgb_valid=0 and all pipeline flags to 0, independent of clk.
REQ-023 SHALL, on reset mid-frame, discard in-flight pixels; the first valid output is 2 edges after the first post-release sample.
REQ-024 SHALL reset the board snapshot (when present) to all zero, so the board shows all empty tiles until the first snapshot.

Configuration
REQ-025 SHALL support the macro TILE_SEL_SNAPSHOT_EN; when defined, board is latched into a 64-bit snapshot register on the cycle with v_cnt==480 and h_cnt==0, and the snapshot drives tile lookup.
REQ-026 SHALL, when TILE_SEL_SNAPSHOT_EN is undefined, use board live in stage 0 with no snapshot register.

Verification
REQ-027 SHALL cover reset: rst_n=0 for 5 cycles during active video -> rgb_out=0, rgb_valid=0, pixel_addr=0 throughout.
REQ-028 SHALL cover the top-left corner: h=120, v=40, valid=1, tile0=1 -> pixel_addr=0 after edge 1; rgb_out=signal1 after edge 2.
REQ-029 SHALL cover the bottom-right corner: h=519, v=439, tile15=11 -> pixel_addr=9999; rgb_out=signal11.
REQ-030 SHALL cover an illegal code: tile5=13, h=250, v=150 -> pixel_addr=1030; rgb_out=12'hF0F.
REQ-031 SHALL cover off-board and blanking: h=100, v=200 -> rgb_out=12'hBBA, pixel_addr=0; valid=0 -> rgb_valid=0 two edges later.
REQ-032 SHALL cover snapshot timing: with the macro, change board at v=200 -> output unchanged until after v=480, h=0; without the macro, the change is visible 2 edges later.
